if_fetch_queue: RTL and testbench
=================================

# if_fetch_queue

Instruction fetch front end with a prefetch queue. It feeds the IF/ID pipeline register. It issues in-order fetch requests to instruction memory and buffers returned instructions with their PCs in a DEPTH-entry FIFO. It presents the oldest entry to decode and pops it only when the downstream stage accepts. On a taken branch or jump from the RF stage it flushes the queue, discards in-flight responses and restarts fetching at the target.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2; also the cap on outstanding memory requests
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- id_ready  in  1  downstream accepts head entry this cycle (IF/ID enable & RF done)
- rf_take_branch_out  in  1  redirect request from RF stage
- rf_target_PC_out  in  32  redirect target
- Imem2proc_valid  in  1  instruction memory response valid
- Imem2proc_data  in  32  instruction word of response
- proc2Imem_req  out  1  fetch request valid
- proc2Imem_addr  out  32  fetch address, word aligned
- if_PC_out  out  32  PC of head entry
- if_NPC_out  out  32  if_PC_out + 4
- if_IR_out  out  32  instruction of head entry; `NOOP_INST when queue empty
- if_valid_inst_out  out  1  head entry valid (queue non-empty)
- fq_count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Registers: fetch_pc, FIFO of {PC, IR} with head/tail pointers, count, outstanding (unanswered requests, 0..DEPTH), discard (responses still to drop, ≤ outstanding).
- Request: proc2Imem_req = !rf_take_branch_out && (count + outstanding) < DEPTH. proc2Imem_addr = fetch_pc. Memory accepts every request. Each request increments fetch_pc by 4 and outstanding by 1.
- Response: memory answers in order, exactly one response per request, latency ≥1 cycle. A response with outstanding==0 is an error; the bench asserts on it.
  - If discard>0: the response is dropped and discard decrements.
  - Otherwise: {PC of oldest live request, Imem2proc_data} is written at tail. PC tracking uses resp_pc, which starts equal to the restart address and advances by 4 per accepted response.
- Pop: when if_valid_inst_out && id_ready, head advances.
- Push and pop in the same cycle: count unchanged. A push into a full queue cannot occur because of the credit rule.
- Redirect (rf_take_branch_out=1) has priority over pop, push and request. Effects:
  - count, head and tail reset to 0.
  - fetch_pc and resp_pc are loaded with {rf_target_PC_out[31:2],2'b00}.
  - discard is loaded with outstanding minus 1 if a response arrives this cycle, else outstanding. That same-cycle response is dropped.
  - No request is issued in the redirect cycle.
- Pointers wrap modulo DEPTH. The credit rule counts queued entries and outstanding requests; popped entries free a credit from the next cycle.

## Timing
- While rst=1 at a clock edge:
  - fetch_pc=RESET_PC, resp_pc=RESET_PC
  - count=0, outstanding=0, discard=0
  - proc2Imem_req=0, proc2Imem_addr=RESET_PC
  - if_valid_inst_out=0, if_IR_out=`NOOP_INST, if_PC_out=0, if_NPC_out=4, fq_count=0
- Reset mid-operation: all state cleared. Responses to requests issued before reset are the memory model's responsibility: the memory is also reset.
- The first request is asserted in the first cycle after rst deasserts.
- Latency: a response in cycle N is visible at the head in cycle N+1 if the queue is empty. There is no bypass.
- With 1-cycle memory: request in cycle 1, response in cycle 2, if_valid_inst_out in cycle 3. Sustained throughput is 1 instruction/cycle with id_ready=1 and DEPTH≥2.
- Head outputs are driven from registers and mux only. There is no combinational path from id_ready to any output. The path from rf_take_branch_out to proc2Imem_req is combinational.
- The first request at the target issues the cycle after the redirect. The first target instruction is valid 2 cycles after that request with 1-cycle memory.

## Test plan
- Reset then stream, 1-cycle memory, id_ready=1 → addresses 0,4,8,... on consecutive cycles; if_valid_inst_out rises in cycle 3 with PC 0, then PC 4, 8 on consecutive cycles; NPC=PC+4.
- Backpressure: id_ready=0 from reset, DEPTH=4 → fq_count reaches 4, req stays low after 4 requests, head holds PC 0. Raise id_ready for 1 cycle → head becomes PC 4 and exactly one new request (addr 0x10) issues the following cycle.
- Redirect with in-flight requests, 3-cycle memory, target 0x100 while outstanding=2 → both stale responses dropped, next request addr 0x100, first valid head PC 0x100 with its IR, no stale IR ever valid.
- Simultaneous redirect, pop and response in one cycle → next cycle fq_count=0, if_valid_inst_out=0, discard = outstanding−1.
- Misaligned target 0x103 → proc2Imem_addr 0x100, head PC 0x100, NPC 0x104.
- Assert rst while queue holds 3 entries and 1 request is outstanding → next cycle fq_count=0, outputs at reset values; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch_queue_if.sv
// Fetch-queue boundary bundle: decode handshake, RF redirect and the instruction memory port.
// The fetch queue uses the master modport and its environment uses the slave modport.
interface if_fetch_queue_if #(
  parameter int unsigned DEPTH = 4
) ();
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             id_ready;
  logic             rf_take_branch_out;
  logic [31:0]      rf_target_PC_out;
  logic             Imem2proc_valid;
  logic [31:0]      Imem2proc_data;
  logic             proc2Imem_req;
  logic [31:0]      proc2Imem_addr;
  logic [31:0]      if_PC_out;
  logic [31:0]      if_NPC_out;
  logic [31:0]      if_IR_out;
  logic             if_valid_inst_out;
  logic [CNT_W-1:0] fq_count;

  modport master (
    input  id_ready,
    input  rf_take_branch_out,
    input  rf_target_PC_out,
    input  Imem2proc_valid,
    input  Imem2proc_data,
    output proc2Imem_req,
    output proc2Imem_addr,
    output if_PC_out,
    output if_NPC_out,
    output if_IR_out,
    output if_valid_inst_out,
    output fq_count
  );

  modport slave (
    output id_ready,
    output rf_take_branch_out,
    output rf_target_PC_out,
    output Imem2proc_valid,
    output Imem2proc_data,
    input  proc2Imem_req,
    input  proc2Imem_addr,
    input  if_PC_out,
    input  if_NPC_out,
    input  if_IR_out,
    input  if_valid_inst_out,
    input  fq_count
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction fetch front end: credit-limited in-order fetch into a DEPTH-entry {PC, IR} queue,
// with flush and restart on an RF-stage redirect.
module if_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  if_fetch_queue_if.master bus
);
  localparam int unsigned PTR_W     = $clog2(DEPTH);
  localparam int unsigned CNT_W     = $clog2(DEPTH + 1);
  localparam logic [31:0] NOOP_INST = 32'h0000_0013;

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic [31:0]      pc_mem_q [DEPTH];
  logic [31:0]      ir_mem_q [DEPTH];

  logic             redirect_c;
  logic             resp_c;
  logic             req_c;
  logic             pop_c;
  logic             push_c;
  logic             head_valid_c;
  logic [31:0]      head_pc_c;
  logic [31:0]      target_c;
  logic [CNT_W:0]   credits_used_c;
  logic             unused_target_lsb;

  assign redirect_c        = bus.rf_take_branch_out;
  assign resp_c            = bus.Imem2proc_valid;
  assign target_c          = {bus.rf_target_PC_out[31:2], 2'b00};
  assign unused_target_lsb = ^bus.rf_target_PC_out[1:0];

  // Every queued entry and every unanswered request holds one credit.
  assign credits_used_c = (CNT_W + 1)'(count_q) + (CNT_W + 1)'(outst_q);
  assign req_c          = !rst && !redirect_c && (credits_used_c < (CNT_W + 1)'(DEPTH));
  assign head_valid_c   = (count_q != '0);
  assign pop_c          = head_valid_c && bus.id_ready;
  assign push_c         = resp_c && (discard_q == '0) && !redirect_c;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    outst_d    = outst_q;
    discard_d  = discard_q;
    if (redirect_c) begin
      // Everything still in flight, less a response landing now, must be dropped.
      fetch_pc_d = target_c;
      resp_pc_d  = target_c;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      outst_d    = outst_q - CNT_W'(resp_c);
      discard_d  = outst_q - CNT_W'(resp_c);
    end else begin
      if (req_c) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      outst_d = outst_q + CNT_W'(req_c) - CNT_W'(resp_c);
      if (resp_c && (discard_q != '0)) begin
        discard_d = discard_q - CNT_W'(1);
      end
      if (push_c) begin
        tail_d    = tail_q + PTR_W'(1);
        resp_pc_d = resp_pc_q + 32'd4;
      end
      if (pop_c) begin
        head_d = head_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
    end
  end

  // Queue storage carries no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push_c) begin
      pc_mem_q[tail_q] <= resp_pc_q;
      ir_mem_q[tail_q] <= bus.Imem2proc_data;
    end
  end

  assign head_pc_c = head_valid_c ? pc_mem_q[head_q] : 32'h0000_0000;

  assign bus.proc2Imem_req     = req_c;
  assign bus.proc2Imem_addr    = fetch_pc_q;
  assign bus.if_valid_inst_out = head_valid_c;
  assign bus.if_PC_out         = head_pc_c;
  assign bus.if_NPC_out        = head_pc_c + 32'd4;
  assign bus.if_IR_out         = head_valid_c ? ir_mem_q[head_q] : NOOP_INST;
  assign bus.fq_count          = count_q;
endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with an in-order fixed-latency instruction memory model.
module tb_if_fetch_queue;
  localparam logic [31:0] NOOP_INST = 32'h0000_0013;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;
  int unsigned mem_lat;
  int unsigned edge_cnt;
  logic [31:0] req_addr_q [$];
  int unsigned req_tag_q [$];

  if_fetch_queue_if #(.DEPTH(4)) bus ();

  if_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: log accepted requests at the clock edge, answer in order after mem_lat edges.
  initial begin
    edge_cnt = 0;
    forever begin
      @(posedge clk);
      if (!rst && bus.Imem2proc_valid && (dut.outst_q == '0)) begin
        tests_run++;
        tests_failed++;
        $display("FAIL resp_without_outstanding got outstanding 0 want >0");
      end
      if (rst) begin
        req_addr_q.delete();
        req_tag_q.delete();
      end else if (bus.proc2Imem_req) begin
        req_addr_q.push_back(bus.proc2Imem_addr);
        req_tag_q.push_back(edge_cnt);
      end
      edge_cnt++;
    end
  end

  initial begin
    bus.Imem2proc_valid = 1'b0;
    bus.Imem2proc_data  = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst && (req_addr_q.size() > 0) && ((edge_cnt - req_tag_q[0]) >= mem_lat)) begin
        bus.Imem2proc_valid = 1'b1;
        bus.Imem2proc_data  = req_addr_q[0] ^ 32'h5EED_0000;
        void'(req_addr_q.pop_front());
        void'(req_tag_q.pop_front());
      end else begin
        bus.Imem2proc_valid = 1'b0;
        bus.Imem2proc_data  = 32'h0;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 1 (first cycle with rst low).
  task automatic do_reset(input int unsigned lat, input logic idr);
    step();
    rst = 1'b1;
    mem_lat = lat;
    bus.id_ready = 1'b0;
    bus.rf_take_branch_out = 1'b0;
    bus.rf_target_PC_out = 32'h0;
    step();
    step();
    rst = 1'b0;
    bus.id_ready = idr;
  endtask

  task automatic test_reset();
    step();
    rst = 1'b1;
    bus.id_ready = 1'b1;
    bus.rf_take_branch_out = 1'b0;
    bus.rf_target_PC_out = 32'h0;
    step();
    step();
    #1;
    tests_run++; if (bus.proc2Imem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req got %0b want 0", bus.proc2Imem_req); end
    tests_run++; if (bus.proc2Imem_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_addr got %h want 00000000", bus.proc2Imem_addr); end
    tests_run++; if (bus.if_valid_inst_out !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %0b want 0", bus.if_valid_inst_out); end
    tests_run++; if (bus.if_IR_out !== NOOP_INST) begin tests_failed++; $display("FAIL reset_ir got %h want %h", bus.if_IR_out, NOOP_INST); end
    tests_run++; if (bus.if_PC_out !== 32'h0) begin tests_failed++; $display("FAIL reset_pc got %h want 00000000", bus.if_PC_out); end
    tests_run++; if (bus.if_NPC_out !== 32'h4) begin tests_failed++; $display("FAIL reset_npc got %h want 00000004", bus.if_NPC_out); end
    tests_run++; if (bus.fq_count !== 3'd0) begin tests_failed++; $display("FAIL reset_count got %0d want 0", bus.fq_count); end
  endtask

  task automatic test_stream();
    do_reset(1, 1'b1);
    #1;
    tests_run++; if (bus.proc2Imem_req !== 1'b1 || bus.proc2Imem_addr !== 32'h0) begin tests_failed++; $display("FAIL stream_c1_req got %0b/%h want 1/00000000", bus.proc2Imem_req, bus.proc2Imem_addr); end
    tests_run++; if (bus.if_valid_inst_out !== 1'b0) begin tests_failed++; $display("FAIL stream_c1_valid got %0b want 0", bus.if_valid_inst_out); end
    step(); #1;
    tests_run++; if (bus.proc2Imem_req !== 1'b1 || bus.proc2Imem_addr !== 32'h4) begin tests_failed++; $display("FAIL stream_c2_req got %0b/%h want 1/00000004", bus.proc2Imem_req, bus.proc2Imem_addr); end
    tests_run++; if (bus.if_valid_inst_out !== 1'b0) begin tests_failed++; $display("FAIL stream_c2_valid got %0b want 0", bus.if_valid_inst_out); end
    for (int k = 0; k < 4; k++) begin
      step(); #1;
      tests_run++; if (bus.if_valid_inst_out !== 1'b1 || bus.if_PC_out !== 32'(4 * k)) begin tests_failed++; $display("FAIL stream_head_pc%0d got %0b/%h want 1/%h", k, bus.if_valid_inst_out, bus.if_PC_out, 32'(4 * k)); end
      tests_run++; if (bus.if_NPC_out !== 32'(4 * k + 4) || bus.if_IR_out !== (32'(4 * k) ^ 32'h5EED_0000)) begin tests_failed++; $display("FAIL stream_head_npc_ir%0d got %h/%h", k, bus.if_NPC_out, bus.if_IR_out); end
      tests_run++; if (bus.proc2Imem_addr !== 32'(4 * k + 8)) begin tests_failed++; $display("FAIL stream_addr%0d got %h want %h", k, bus.proc2Imem_addr, 32'(4 * k + 8)); end
    end
  endtask

  task automatic test_backpressure();
    do_reset(1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      #1;
      tests_run++; if (bus.proc2Imem_req !== 1'b1 || bus.proc2Imem_addr !== 32'(4 * k)) begin tests_failed++; $display("FAIL bp_req%0d got %0b/%h want 1/%h", k, bus.proc2Imem_req, bus.proc2Imem_addr, 32'(4 * k)); end
      step();
    end
    #1;
    tests_run++; if (bus.proc2Imem_req !== 1'b0) begin tests_failed++; $display("FAIL bp_credit_stop got %0b want 0", bus.proc2Imem_req); end
    step(); #1;
    tests_run++; if (bus.fq_count !== 3'd4 || bus.proc2Imem_req !== 1'b0) begin tests_failed++; $display("FAIL bp_full got count %0d req %0b want 4/0", bus.fq_count, bus.proc2Imem_req); end
    tests_run++; if (bus.if_valid_inst_out !== 1'b1 || bus.if_PC_out !== 32'h0) begin tests_failed++; $display("FAIL bp_head_hold got %0b/%h want 1/00000000", bus.if_valid_inst_out, bus.if_PC_out); end
    step();
    bus.id_ready = 1'b1;
    #1;
    tests_run++; if (bus.proc2Imem_req !== 1'b0) begin tests_failed++; $display("FAIL bp_no_comb_credit got %0b want 0", bus.proc2Imem_req); end
    step();
    bus.id_ready = 1'b0;
    #1;
    tests_run++; if (bus.if_PC_out !== 32'h4 || bus.if_IR_out !== 32'h5EED_0004) begin tests_failed++; $display("FAIL bp_head_adv got %h/%h want 00000004/5eed0004", bus.if_PC_out, bus.if_IR_out); end
    tests_run++; if (bus.proc2Imem_req !== 1'b1 || bus.proc2Imem_addr !== 32'h10) begin tests_failed++; $display("FAIL bp_one_req got %0b/%h want 1/00000010", bus.proc2Imem_req, bus.proc2Imem_addr); end
    tests_run++; if (bus.fq_count !== 3'd3) begin tests_failed++; $display("FAIL bp_count_after_pop got %0d want 3", bus.fq_count); end
    step(); #1;
    tests_run++; if (bus.proc2Imem_req !== 1'b0) begin tests_failed++; $display("FAIL bp_only_one got %0b want 0", bus.proc2Imem_req); end
    step(); #1;
    tests_run++; if (bus.fq_count !== 3'd4 || bus.proc2Imem_req !== 1'b0) begin tests_failed++; $display("FAIL bp_refull got count %0d req %0b want 4/0", bus.fq_count, bus.proc2Imem_req); end
  endtask

  task automatic test_redirect_inflight();
    do_reset(3, 1'b1);
    step();
    step();
    bus.rf_take_branch_out = 1'b1;
    bus.rf_target_PC_out = 32'h100;
    #1;
    tests_run++; if (bus.proc2Imem_req !== 1'b0) begin tests_failed++; $display("FAIL redir_no_req got %0b want 0", bus.proc2Imem_req); end
    step();
    bus.rf_take_branch_out = 1'b0;
    #1;
    tests_run++; if (bus.proc2Imem_req !== 1'b1 || bus.proc2Imem_addr !== 32'h100) begin tests_failed++; $display("FAIL redir_target_req got %0b/%h want 1/00000100", bus.proc2Imem_req, bus.proc2Imem_addr); end
    for (int c = 4; c < 8; c++) begin
      tests_run++; if (bus.if_valid_inst_out !== 1'b0) begin tests_failed++; $display("FAIL redir_stale_c%0d got valid 1 pc %h ir %h want valid 0", c, bus.if_PC_out, bus.if_IR_out); end
      step(); #1;
    end
    tests_run++; if (bus.if_valid_inst_out !== 1'b1 || bus.if_PC_out !== 32'h100 || bus.if_IR_out !== 32'h5EED_0100) begin tests_failed++; $display("FAIL redir_first got %0b/%h/%h want 1/00000100/5eed0100", bus.if_valid_inst_out, bus.if_PC_out, bus.if_IR_out); end
    step(); #1;
    tests_run++; if (bus.if_valid_inst_out !== 1'b1 || bus.if_PC_out !== 32'h104 || bus.if_IR_out !== 32'h5EED_0104) begin tests_failed++; $display("FAIL redir_second got %0b/%h/%h want 1/00000104/5eed0104", bus.if_valid_inst_out, bus.if_PC_out, bus.if_IR_out); end
  endtask

  task automatic test_simultaneous();
    do_reset(2, 1'b1);
    step();
    step();
    step();
    #1;
    tests_run++; if (bus.if_valid_inst_out !== 1'b1 || bus.if_PC_out !== 32'h0) begin tests_failed++; $display("FAIL simul_pre_head got %0b/%h want 1/00000000", bus.if_valid_inst_out, bus.if_PC_out); end
    bus.rf_take_branch_out = 1'b1;
    bus.rf_target_PC_out = 32'h200;
    step();
    bus.rf_take_branch_out = 1'b0;
    #1;
    tests_run++; if (bus.fq_count !== 3'd0 || bus.if_valid_inst_out !== 1'b0) begin tests_failed++; $display("FAIL simul_flush got count %0d valid %0b want 0/0", bus.fq_count, bus.if_valid_inst_out); end
    tests_run++; if (dut.discard_q !== 3'd1 || dut.outst_q !== 3'd1) begin tests_failed++; $display("FAIL simul_discard got discard %0d outst %0d want 1/1", dut.discard_q, dut.outst_q); end
    tests_run++; if (bus.proc2Imem_req !== 1'b1 || bus.proc2Imem_addr !== 32'h200) begin tests_failed++; $display("FAIL simul_restart got %0b/%h want 1/00000200", bus.proc2Imem_req, bus.proc2Imem_addr); end
    step(); step(); #1;
    tests_run++; if (bus.if_valid_inst_out !== 1'b0) begin tests_failed++; $display("FAIL simul_stale got valid 1 pc %h want valid 0", bus.if_PC_out); end
    step(); #1;
    tests_run++; if (bus.if_valid_inst_out !== 1'b1 || bus.if_PC_out !== 32'h200 || bus.if_IR_out !== 32'h5EED_0200) begin tests_failed++; $display("FAIL simul_first got %0b/%h/%h want 1/00000200/5eed0200", bus.if_valid_inst_out, bus.if_PC_out, bus.if_IR_out); end
  endtask

  task automatic test_misaligned();
    do_reset(1, 1'b1);
    step();
    step();
    bus.rf_take_branch_out = 1'b1;
    bus.rf_target_PC_out = 32'h103;
    step();
    bus.rf_take_branch_out = 1'b0;
    #1;
    tests_run++; if (bus.proc2Imem_req !== 1'b1 || bus.proc2Imem_addr !== 32'h100) begin tests_failed++; $display("FAIL misal_addr got %0b/%h want 1/00000100", bus.proc2Imem_req, bus.proc2Imem_addr); end
    tests_run++; if (bus.if_valid_inst_out !== 1'b0) begin tests_failed++; $display("FAIL misal_flush got %0b want 0", bus.if_valid_inst_out); end
    step(); #1;
    tests_run++; if (bus.if_valid_inst_out !== 1'b0) begin tests_failed++; $display("FAIL misal_stale got %0b want 0", bus.if_valid_inst_out); end
    step(); #1;
    tests_run++; if (bus.if_valid_inst_out !== 1'b1 || bus.if_PC_out !== 32'h100 || bus.if_NPC_out !== 32'h104) begin tests_failed++; $display("FAIL misal_head got %0b/%h/%h want 1/00000100/00000104", bus.if_valid_inst_out, bus.if_PC_out, bus.if_NPC_out); end
    tests_run++; if (bus.if_IR_out !== 32'h5EED_0100) begin tests_failed++; $display("FAIL misal_ir got %h want 5eed0100", bus.if_IR_out); end
  endtask

  task automatic test_reset_midop();
    do_reset(1, 1'b0);
    step(); step(); step(); step();
    #1;
    tests_run++; if (bus.fq_count !== 3'd3 || bus.proc2Imem_req !== 1'b0) begin tests_failed++; $display("FAIL midrst_pre got count %0d req %0b want 3/0", bus.fq_count, bus.proc2Imem_req); end
    rst = 1'b1;
    step(); #1;
    tests_run++; if (bus.fq_count !== 3'd0 || bus.if_valid_inst_out !== 1'b0) begin tests_failed++; $display("FAIL midrst_flush got count %0d valid %0b want 0/0", bus.fq_count, bus.if_valid_inst_out); end
    tests_run++; if (bus.if_IR_out !== NOOP_INST || bus.if_PC_out !== 32'h0 || bus.if_NPC_out !== 32'h4) begin tests_failed++; $display("FAIL midrst_head got %h/%h/%h want %h/00000000/00000004", bus.if_IR_out, bus.if_PC_out, bus.if_NPC_out, NOOP_INST); end
    tests_run++; if (bus.proc2Imem_req !== 1'b0 || bus.proc2Imem_addr !== 32'h0) begin tests_failed++; $display("FAIL midrst_req got %0b/%h want 0/00000000", bus.proc2Imem_req, bus.proc2Imem_addr); end
    step();
    rst = 1'b0;
    #1;
    tests_run++; if (bus.proc2Imem_req !== 1'b1 || bus.proc2Imem_addr !== 32'h0) begin tests_failed++; $display("FAIL midrst_restart got %0b/%h want 1/00000000", bus.proc2Imem_req, bus.proc2Imem_addr); end
    step(); #1;
    tests_run++; if (bus.proc2Imem_addr !== 32'h4) begin tests_failed++; $display("FAIL midrst_addr2 got %h want 00000004", bus.proc2Imem_addr); end
    step(); #1;
    tests_run++; if (bus.if_valid_inst_out !== 1'b1 || bus.if_PC_out !== 32'h0 || bus.if_IR_out !== 32'h5EED_0000) begin tests_failed++; $display("FAIL midrst_head_again got %0b/%h/%h want 1/00000000/5eed0000", bus.if_valid_inst_out, bus.if_PC_out, bus.if_IR_out); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    mem_lat      = 1;
    bus.id_ready = 1'b0;
    bus.rf_take_branch_out = 1'b0;
    bus.rf_target_PC_out = 32'h0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_simultaneous();
    test_misaligned();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
